mem_port_arbiter: RTL

- Shares the single-port data RAM between two requesters: the instruction fetch port (IF) and the load/store memory stage (DM).
- Sits between the fetch/memory pipeline stages and the RAM instance.
- Sequences each access: grant, address/write phase, fixed read-latency wait, one-cycle response pulse.
- DM has priority; a streak limiter guarantees IF forward progress.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the IF/DM requesters, the arbiter and the single-port RAM.
// Handshake: a requester holds req (and its addr/we/wdata) as a level until its ready pulses for one cycle; that pulse completes the access.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [31:0]       if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_ready;
  logic [31:0]       dm_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_data_in;
  logic              ram_write_enable;
  logic [31:0]       ram_data_out;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_data_out,
    output if_ready, if_rdata, dm_ready, dm_rdata,
           ram_address, ram_data_in, ram_write_enable, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_data_out,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
           ram_address, ram_data_in, ram_write_enable, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port data RAM: DM has priority, a
// streak limiter forces an IF grant after MAX_STREAK contested DM grants.
module mem_port_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_STREAK   = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state_o
);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int STK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic              gnt_dm_q, gnt_dm_d;
  logic              wr_q, wr_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              dm_wins;
  logic              if_wins;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      streak_q    <= '0;
      gnt_dm_q    <= 1'b0;
      wr_q        <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      streak_q    <= streak_d;
      gnt_dm_q    <= gnt_dm_d;
      wr_q        <= wr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    streak_d    = streak_q;
    gnt_dm_d    = gnt_dm_q;
    wr_d        = wr_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    // IF only beats a pending DM request once the contested streak is full.
    dm_wins     = bus.dm_req && !(bus.if_req && (streak_q == STK_MAX));
    if_wins     = bus.if_req && !dm_wins;

    unique case (state_q)
      IDLE: begin
        if (!bus.if_req || if_wins) begin
          streak_d = '0;
        end else if (streak_q != STK_MAX) begin
          streak_d = streak_q + 1'b1;
        end

        if (dm_wins) begin
          gnt_dm_d    = 1'b1;
          wr_d        = bus.dm_we;
          ram_we_d    = bus.dm_we;
          ram_addr_d  = bus.dm_addr;
          ram_wdata_d = bus.dm_wdata;
          lat_d       = LAT_LOAD;
          state_d     = ACCESS;
        end else if (if_wins) begin
          gnt_dm_d   = 1'b0;
          wr_d       = 1'b0;
          ram_addr_d = bus.if_addr;
          lat_d      = LAT_LOAD;
          state_d    = ACCESS;
        end
      end

      ACCESS: begin
        if (wr_q) begin
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
          // Last latency cycle: RAM output is valid at this edge.
          if (lat_q == LAT_W'(1)) begin
            state_d = RESP;
            if (gnt_dm_q) begin
              dm_rdata_d = bus.ram_data_out;
            end else begin
              if_rdata_d = bus.ram_data_out;
            end
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.if_ready         = (state_q == RESP) && !gnt_dm_q;
  assign bus.dm_ready         = (state_q == RESP) && gnt_dm_q;
  assign bus.if_rdata         = if_rdata_q;
  assign bus.dm_rdata         = dm_rdata_q;
  assign bus.ram_address      = ram_addr_q;
  assign bus.ram_data_in      = ram_wdata_q;
  assign bus.ram_write_enable = ram_we_q;
  assign bus.busy             = (state_q != IDLE);
  assign dbg_state_o          = state_q;

  a_one_ready: assert property (@(posedge clk) disable iff (!rst)
    !(bus.if_ready && bus.dm_ready));
  a_we_in_access: assert property (@(posedge clk) disable iff (!rst)
    bus.ram_write_enable |-> (state_q == ACCESS));
endmodule
